// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - PWM audio output stage with pop-free ramp and amplifier shutdown control
//
// Drives the mono audio pin with a 2^W-clock PWM period whose duty follows the
// mixed voice sample. Duty and state change only at the period boundary
// (cnt == 2^W-1). A ramp FSM fades the duty in/out when en changes so the
// speaker does not pop.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   en          audio enable, sampled at period boundaries
//   sample_in   unsigned mixed sample, sampled at period boundaries
//   pwm_out     registered PWM drive, high while cnt < level (one clk latency)
//   amp_sd_n    registered amplifier shutdown, low only in OFF
//   sample_tick one-cycle pulse in the boundary cycle (sample capture)
//   level       duty value currently in effect
module audio_pwm_out #(
  parameter int W         = 10,
  parameter int RAMP_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] sample_in,
  output logic         pwm_out,
  output logic         amp_sd_n,
  output logic         sample_tick,
  output logic [W-1:0] level
);

  typedef enum logic [1:0] {
    S_OFF,
    S_RAMP_UP,
    S_RUN,
    S_RAMP_DOWN
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W:0]   STEP    = (W+1)'(RAMP_STEP);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] level_q, level_d;
  state_t       state_q, state_d;
  logic         pwm_q, pwm_d;
  logic         amp_q, amp_d;

  logic         boundary;
  logic [W:0]   up_sum;
  logic [W:0]   sample_ext;
  logic [W-1:0] dn_level;

  always_comb begin
    cnt_d      = cnt_q + W'(1);
    boundary   = (cnt_q == CNT_MAX);
    sample_ext = {1'b0, sample_in};

    // Ramp intermediates are one bit wider so level+step cannot wrap.
    up_sum = {1'b0, level_q} + STEP;

    // Saturate at zero instead of underflowing.
    if ({1'b0, level_q} <= STEP) begin
      dn_level = '0;
    end else begin
      dn_level = level_q - STEP[W-1:0];
    end

    state_d = state_q;
    level_d = level_q;

    if (boundary) begin
      unique case (state_q)
        S_OFF: begin
          level_d = '0;
          if (en) begin
            state_d = S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (!en) begin
            state_d = S_RAMP_DOWN;
          end else if (up_sum >= sample_ext) begin
            // Reached the target, or the target fell below the current level.
            level_d = sample_in;
            state_d = S_RUN;
          end else begin
            level_d = up_sum[W-1:0];
          end
        end
        S_RUN: begin
          if (en) begin
            level_d = sample_in;
          end else begin
            state_d = S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          if (en) begin
            state_d = S_RAMP_UP;
          end else begin
            level_d = dn_level;
            if (dn_level == '0) begin
              state_d = S_OFF;
            end
          end
        end
        default: begin
          state_d = S_OFF;
          level_d = '0;
        end
      endcase
    end

    pwm_d = (cnt_q < level_q);
    // Amplifier follows the state being entered so it switches on the same edge.
    amp_d = (state_d != S_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= '0;
      state_q <= S_OFF;
      pwm_q   <= 1'b0;
      amp_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      state_q <= state_d;
      pwm_q   <= pwm_d;
      amp_q   <= amp_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign amp_sd_n    = amp_q;
  assign sample_tick = boundary;
  assign level       = level_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - scoreboard testbench for audio_pwm_out
module tb_audio_pwm_out;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] sample_in;
  logic         pwm_out;
  logic         amp_sd_n;
  logic         sample_tick;
  logic [W-1:0] level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   lvl;
    logic amp;
    int   hi;
  } exp_t;

  exp_t sb[$];

  audio_pwm_out #(.W(W), .RAMP_STEP(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sample_in   (sample_in),
    .pwm_out     (pwm_out),
    .amp_sd_n    (amp_sd_n),
    .sample_tick (sample_tick),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int l, input logic a, input int h);
    exp_t e;
    e.lvl = l;
    e.amp = a;
    e.hi  = h;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the boundary cycle, step past the boundary edge, check
  // the loaded level/amp against the scoreboard, then count pwm highs over
  // cnt=1..1023 (pwm reflects cnt-1 < level). Ends on the next boundary cycle.
  task automatic period(input string tag, input int chg_at, input logic [W-1:0] chg_val);
    exp_t e;
    int   n;
    int   hi;
    n = 0;
    while (sample_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick"}, {31'd0, sample_tick}, 32'd1);
    @(negedge clk);
    chk({tag, "_tick_low"}, {31'd0, sample_tick}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_level"}, {22'd0, level}, e.lvl);
    chk({tag, "_amp"}, {31'd0, amp_sd_n}, {31'd0, e.amp});
    hi = 0;
    for (int c = 1; c <= 1023; c++) begin
      @(negedge clk);
      if (c == chg_at) sample_in = chg_val;
      if (c == 1) chk({tag, "_first_hi"}, {31'd0, pwm_out}, (e.lvl > 0) ? 32'd1 : 32'd0);
      if (pwm_out === 1'b1) hi++;
    end
    chk({tag, "_high_clks"}, hi, e.hi);
  endtask

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    en = 1'b1;
    sample_in = 10'd700;

    // Reset hold
    repeat (5) @(negedge clk);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_amp", {31'd0, amp_sd_n}, 32'd0);
    chk("rst_level", {22'd0, level}, 32'd0);
    chk("rst_tick", {31'd0, sample_tick}, 32'd0);
    rst = 1'b0;
    n = 0;
    while (sample_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("first_tick_clk", n, 1023);
    chk("first_period_amp", {31'd0, amp_sd_n}, 32'd0);

    // Ramp up to 5
    sample_in = 10'd5;
    push(0, 1'b1, 0);
    push(1, 1'b1, 1);
    push(2, 1'b1, 2);
    push(3, 1'b1, 3);
    push(4, 1'b1, 4);
    push(5, 1'b1, 5);
    push(5, 1'b1, 5);
    for (int i = 0; i < 7; i++) period("ramp_up", -1, '0);

    // Mid-period sample change
    sample_in = 10'd100;
    push(100, 1'b1, 100);
    period("mid_chg", 300, 10'd512);
    push(512, 1'b1, 512);
    period("mid_next", -1, '0);

    // Ramp down from 3
    sample_in = 10'd3;
    push(3, 1'b1, 3);
    period("run3", -1, '0);
    en = 1'b0;
    push(3, 1'b1, 3);
    push(2, 1'b1, 2);
    push(1, 1'b1, 1);
    push(0, 1'b0, 0);
    push(0, 1'b0, 0);
    for (int i = 0; i < 5; i++) period("ramp_down", -1, '0);

    // Extremes
    en = 1'b1;
    sample_in = 10'd0;
    push(0, 1'b1, 0);
    push(0, 1'b1, 0);
    push(0, 1'b1, 0);
    for (int i = 0; i < 3; i++) period("zero", -1, '0);
    sample_in = 10'd1023;
    push(1023, 1'b1, 1023);
    period("full", -1, '0);

    // Reversal during ramp up at level 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample_in = 10'd50;
    push(0, 1'b1, 0);
    push(1, 1'b1, 1);
    push(2, 1'b1, 2);
    for (int i = 0; i < 3; i++) period("rev_up", -1, '0);
    en = 1'b0;
    push(2, 1'b1, 2);
    period("rev_down", -1, '0);
    en = 1'b1;
    push(2, 1'b1, 2);
    push(3, 1'b1, 3);
    push(4, 1'b1, 4);
    push(5, 1'b1, 5);
    push(6, 1'b1, 6);
    for (int i = 0; i < 5; i++) period("rev_again", -1, '0);

    // Async reset mid-ramp at level 7, cnt=400
    push(7, 1'b1, 7);
    n = 0;
    while (sample_tick !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("lvl7_tick", {31'd0, sample_tick}, 32'd1);
    @(negedge clk);
    e = sb.pop_front();
    chk("lvl7_level", {22'd0, level}, e.lvl);
    chk("lvl7_amp", {31'd0, amp_sd_n}, {31'd0, e.amp});
    repeat (400) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", {31'd0, pwm_out}, 32'd0);
    chk("async_amp", {31'd0, amp_sd_n}, 32'd0);
    chk("async_level", {22'd0, level}, 32'd0);
    chk("async_tick", {31'd0, sample_tick}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sample_in = 10'd5;
    en = 1'b1;
    push(0, 1'b1, 0);
    push(1, 1'b1, 1);
    for (int i = 0; i < 2; i++) period("restart", -1, '0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
Output stage directly downstream of the sound sample selector. It takes the 10-bit mixed voice sample and drives the board's mono audio pin with a fixed-period PWM waveform, and it controls the amplifier shutdown pin. A ramp state machine fades the output level up and down on enable and disable so the speaker does not pop. It also returns a one-cycle tick marking each sample capture.

Parameters:
W, 10, sample width; the PWM period is 2^W clocks (1024 clk = 97.66 kHz at 100 MHz)
RAMP_STEP, 1, amount the level moves per PWM period while ramping

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset
en  input  1  audio enable (from switch or CPU sound-enable bit)
sample_in  input  W  unsigned mixed sample from the sample selector
pwm_out  output  1  PWM audio drive, registered
amp_sd_n  output  1  amplifier shutdown, active low, registered
sample_tick  output  1  one-cycle pulse in the cycle sample_in is captured
level  output  W  duty value currently in effect

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. While rst is high or on assertion: cnt=0, level=0, state=OFF, pwm_out=0, amp_sd_n=0, sample_tick=0.
- Period counter:
  - cnt is W bits, free-running, +1 per clk, wraps 2^W-1 -> 0.
  - Boundary cycle means cnt==2^W-1.
- sample_tick: equals 1 exactly in boundary cycles, 0 otherwise.
- Boundary sampling:
  - sample_in and en are sampled only in boundary cycles.
  - All level and state updates occur only at the boundary clock edge.
  - Changes to sample_in or en between boundaries have no effect; an en pulse shorter than one period may be missed.
- PWM output:
  - pwm_out(t+1) = (cnt(t) < level(t)), so there is one cycle of latency.
  - A level loaded at a boundary governs the whole next period.
  - level=0 gives constant low. level=2^W-1 gives high for 2^W-1 clocks and low for 1 clock.
- FSM, evaluated at each boundary edge:
  - OFF: level=0. If en=1 -> RAMP_UP; amp_sd_n goes to 1 at the same edge.
  - RAMP_UP:
    - If en=0 -> RAMP_DOWN; level is unchanged at this edge.
    - Else level <= min(level+RAMP_STEP, sample_in), computed W+1 bits wide (no wrap).
    - If the new level equals sample_in -> RUN.
    - If sample_in < level, the level drops to sample_in at once and the state goes to RUN.
  - RUN:
    - If en=1, level <= sample_in.
    - If en=0 -> RAMP_DOWN; level is unchanged at this edge.
  - RAMP_DOWN:
    - If en=1 -> RAMP_UP; level is unchanged.
    - Else level <= max(level-RAMP_STEP, 0), computed signed/saturating (no underflow).
    - If the new level is 0 -> OFF; amp_sd_n goes to 0 at the same edge.
- Ramp entry from level 0 when sample_in=0: level stays 0 and the state moves RAMP_UP -> RUN at the next boundary.
- amp_sd_n is 1 in RAMP_UP, RUN and RAMP_DOWN; it is 0 only in OFF.
- Reset mid-operation: all outputs return to reset values immediately. After release the block restarts in OFF with cnt=0.
- level output always equals the internal duty register.
- Widths: all arithmetic is unsigned W bits except the ramp intermediates (W+1 bits).

Test Plan:
- Reset: hold rst for 5 clk with en=1 and sample_in=700 -> pwm_out=0, amp_sd_n=0, level=0, sample_tick=0. After release, the first sample_tick occurs at clk 1023 (cnt=1023).
- Ramp up: en=1, sample_in=5, RAMP_STEP=1 -> level is 1,2,3,4,5 at successive boundaries, then RUN. amp_sd_n=1 from the first boundary. In steady state pwm_out is high exactly 5 of every 1024 clks, starting one clk after cnt=0.
- Mid-period sample change: in RUN at level 100, set sample_in=512 at cnt=300 -> the current period still has 100 high clks. The next period has 512 high clks; level=512 after the boundary.
- Ramp down: in RUN at level 3, drop en -> first boundary: RAMP_DOWN with level 3. Following boundaries give 2, 1, 0. At the edge where level reaches 0, state=OFF and amp_sd_n=0. pwm_out stays low thereafter.
- Extremes and reversal:
  - sample_in=0 in RUN -> pwm_out constant 0.
  - sample_in=1023 in RUN -> exactly 1 low clk per period.
  - en toggled 1->0->1 across boundaries during RAMP_UP at level 2 -> state goes RAMP_DOWN, then RAMP_UP, with level held at 2 across both transitions.
- Async reset mid-ramp: assert rst at level 7 in RAMP_UP with cnt=400 -> outputs clear in the same cycle. After release with en=1 and sample_in=5, the ramp restarts from level 1.
